instr_fetch: RTL
================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000; first fetch address after reset.
REQ-002 Parameter FQ_DEPTH, default 2; fetch-queue entries, legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 fetch_en  input  1  1 = new fetch requests permitted.
REQ-006 redirect_valid  input  1  1 = flush and restart fetch at redirect_pc.
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_rd  output  1  read strobe to instruction_mem.
REQ-009 imem_addr  output  32  byte address to instruction_mem.
REQ-010 imem_instr  input  32  instruction_mem read data; valid the cycle after imem_rd=1.
REQ-011 out_valid  output  1  fetched instruction available to decode.
REQ-012 out_ready  input  1  decode accepts; transfer when out_valid && out_ready.
REQ-013 out_instr  output  32  instruction word at queue head.
REQ-014 out_pc  output  32  address of out_instr.

Function
REQ-015 Two states: BOOT, RUN. BOOT is entered on rst and lasts exactly one cycle, with no request issued. The block then goes to RUN and stays there until rst.
REQ-016 In RUN, imem_rd=1 when all of the following hold: fetch_en=1; redirect_valid=0; (fq_count + resp_pending - pop) < FQ_DEPTH, where pop = out_valid && out_ready.
REQ-017 imem_addr equals pc at all times; pc[1:0] is always 2'b00.
REQ-018 When a request issues, pc <= pc + 4 (mod 2^32); 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-019 resp_pending <= imem_rd && !redirect_valid, and a copy of the issuing pc is held alongside it.
REQ-020 When resp_pending=1 and redirect_valid=0, {imem_instr, held pc} is written into the queue at the end of that cycle.
REQ-021 Request-to-out_valid latency is 2 cycles. With out_ready held at 1 and fetch_en held at 1, one instruction is delivered per cycle.
REQ-022 out_valid = (fq_count != 0) && !redirect_valid. out_instr and out_pc show the queue head and stay stable while out_valid=1 and out_ready=0.
REQ-023 Simultaneous queue write and pop in one cycle is legal; fq_count is then unchanged.
REQ-024 The queue never overflows; REQ-016 guarantees space for every response. An overflow is an assertion failure.
REQ-025 On redirect_valid=1, with priority over every other event:
- the queue is flushed (fq_count <= 0);
- resp_pending <= 0 and the in-flight response is discarded;
- pc <= {redirect_pc[31:2], 2'b00};
- no request issues and no pop occurs that cycle.
REQ-026 The first request after a redirect issues in the following cycle at the new pc (subject to REQ-016).
REQ-027 A redirect during BOOT loads pc; the first request uses the redirect address.
REQ-028 fetch_en=0 stops only new requests. A pending response still completes into the queue, and the queue still drains.

Reset
REQ-029 On rst=1 at a rising edge:
- state <= BOOT, pc <= RESET_PC;
- fq_count, queue read/write pointers and resp_pending <= 0.
REQ-030 During reset and in BOOT: imem_rd=0, out_valid=0, imem_addr=RESET_PC, out_instr=0, out_pc=0.
REQ-031 rst has priority over redirect_valid. Reset mid-operation discards all queued and in-flight instructions.

Structure
REQ-032 XLEN (32), RESET_PC default, the state enum {BOOT, RUN} and the fetch-entry struct {instr, pc} live in shared package riscv_pkg.
REQ-033 The queue is a separate sub-module fetch_fifo, parameterised by depth and entry width. It supports simultaneous push/pop and synchronous flush.
REQ-034 The bench instantiates instr_fetch driving instruction_mem directly (imem_rd->rd, imem_addr->instr_addr, instr->imem_instr).

Verification
REQ-035 Reset release, fetch_en=1, out_ready=1, memory words 0..3 = 00000013, 00100093, 00200113, 00300193:
- imem_rd first rises in cycle 1 after reset;
- out_pc sequence is 0x0, 0x4, 0x8, 0xC on consecutive cycles with matching out_instr.
REQ-036 out_ready=0 for 6 cycles with FQ_DEPTH=2:
- imem_rd drops after 2 issues;
- fq_count saturates at 2 and out_instr holds 00000013;
- on release, the next delivered instructions are pc 0x4 then 0x8, with none lost or duplicated.
REQ-037 Redirect to 0x0000_0103 with 2 entries queued and 1 in flight:
- next cycle out_valid=0 and imem_addr=0x100;
- two cycles later out_pc=0x100;
- no stale pc (0x8, 0xC) ever appears on the output.
REQ-038 pc=0xFFFF_FFFC, one fetch issued: the next imem_addr is 0x0000_0000.
REQ-039 rst asserted for one cycle mid-stream with the queue full:
- out_valid=0 the following cycle;
- imem_rd=0 in BOOT;
- fetch restarts at RESET_PC.
REQ-040 fetch_en dropped for 3 cycles: the pending response still arrives, no new requests issue, and fetch resumes at the next sequential pc.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared fetch-path types: data width, boot address, fetch FSM states and queue entry layout.
package riscv_pkg;

   localparam int unsigned XLEN = 32;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic {
      StBoot,
      StRun
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   localparam int unsigned FETCH_ENTRY_W = $bits(fetch_entry_t);

   // Instructions are word aligned; the low two address bits are forced to zero.
   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular fetch queue with simultaneous push/pop and a synchronous flush.
module fetch_fifo #(
   parameter int unsigned Depth = 2,
   parameter int unsigned Width = 64,
   localparam int unsigned CntW = $clog2(Depth + 1),
   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [Width-1:0] wdata_i,
   input  logic             pop_i,
   output logic [Width-1:0] rdata_o,
   output logic [CntW-1:0]  count_o
);

   logic [Width-1:0] mem_q [Depth];
   logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]  count_q, count_d;
   logic             full, empty, do_push, do_pop;

   // Depth need not be a power of two, so pointers wrap explicitly.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
   endfunction

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(Depth));
   assign do_pop  = pop_i && !empty;
   assign do_push = push_i && (!full || do_pop);

   // Next-state for pointers and occupancy; flush wins over push/pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; payload needs no reset because occupancy gates the read side.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i && !rst_i) begin
         mem_q[wr_ptr_q] <= wdata_i;
      end
   end

   assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];
   assign count_o = count_q;

   // The producer's credit check must make a push into a full, non-draining queue impossible.
   a_no_overflow : assert property (@(posedge clk_i) disable iff (rst_i)
      !(push_i && full && !do_pop && !flush_i));

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word reads, queues responses and hands them to decode.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int unsigned     FQ_DEPTH = 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_en,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_rd,
   output logic [XLEN-1:0] imem_addr,
   input  logic [XLEN-1:0] imem_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc
);

   localparam int unsigned CntW = $clog2(FQ_DEPTH + 1);

   fetch_state_e    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] resp_pc_q;
   logic            resp_pending_q;
   logic [CntW-1:0] fq_count;
   logic [CntW:0]   occupancy;
   logic            pop, push;
   fetch_entry_t    push_entry, head_entry;

   assign out_valid = !rst && (fq_count != '0) && !redirect_valid;
   assign pop       = out_valid && out_ready;
   assign push      = resp_pending_q && !redirect_valid;

   // Credit check: queued plus in-flight, less what leaves this cycle, must leave room.
   assign occupancy = {1'b0, fq_count} + {{CntW{1'b0}}, resp_pending_q}
                    - {{CntW{1'b0}}, pop};

   assign imem_rd   = !rst && (state_q == StRun) && fetch_en && !redirect_valid
                    && (occupancy < (CntW + 1)'(FQ_DEPTH));
   assign imem_addr = rst ? RESET_PC : pc_q;

   assign push_entry = '{instr: imem_instr, pc: resp_pc_q};
   assign out_instr  = rst ? '0 : head_entry.instr;
   assign out_pc     = rst ? '0 : head_entry.pc;

   // Boot/run sequencing, fetch pc and the one outstanding memory response.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StBoot;
         pc_q           <= RESET_PC;
         resp_pending_q <= 1'b0;
         resp_pc_q      <= '0;
      end else begin
         state_q <= StRun;
         if (redirect_valid) begin
            pc_q           <= word_align(redirect_pc);
            resp_pending_q <= 1'b0;
         end else begin
            resp_pending_q <= imem_rd;
            if (imem_rd) begin
               pc_q      <= pc_q + XLEN'(4);
               resp_pc_q <= pc_q;
            end
         end
      end
   end

   fetch_fifo #(
      .Depth (FQ_DEPTH),
      .Width (FETCH_ENTRY_W)
   ) u_fetch_fifo (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (redirect_valid),
      .push_i  (push),
      .wdata_i (push_entry),
      .pop_i   (pop),
      .rdata_o (head_entry),
      .count_o (fq_count)
   );

endmodule
